// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - per-phase clock-enable and end-of-phase strobe sequencer
// with phase-skip mask, debounced RUN/STEP panel inputs and boundary-deferred halt.
module phase_sequencer #(
  parameter int NPHASE    = 10,
  parameter int TICKS     = 2,
  parameter int DEB_LIMIT = 250000
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      RUN,
  input  logic                      STEP,
  input  logic                      HALT,
  input  logic                      DONE,
  input  logic [NPHASE-1:0]         SKIP,
  output logic [NPHASE-1:0]         CK,
  output logic [NPHASE-1:0]         STB,
  output logic [$clog2(NPHASE)-1:0] PHASE,
  output logic                      INSTR_END,
  output logic                      running
);

  localparam int PW = $clog2(NPHASE);
  localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int DW = $clog2(DEB_LIMIT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic                 halt_pend_q, halt_pend_d;
  logic [NPHASE-1:0]    skip_lat_q, skip_lat_d;

  // Channel 0 is RUN, channel 1 is STEP.
  logic [1:0]           raw;
  logic [1:0][DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [1:0]           deb_stb_q, deb_stb_d;
  logic [1:0]           go_q, go_d;

  logic                 active;
  logic                 last_tick;
  logic [NPHASE-1:0]    eff_skip;
  logic [PW-1:0]        nxt_phase;
  logic                 has_nxt;
  logic                 instr_end;

  assign raw = {STEP, RUN};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      deb_stb_d[i] = deb_stb_q[i];
      go_d[i]      = 1'b0;
      if (raw[i] != deb_stb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_stb_d[i] = raw[i];
          go_d[i]      = raw[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  assign active    = (state_q != S_IDLE);
  assign last_tick = (tick_q == TICK_LAST);

  // Leaving phase 0 uses the mask arriving this cycle; later phases use the latched copy.
  always_comb begin
    eff_skip  = (phase_q == '0) ? (SKIP & ~NPHASE'(1)) : skip_lat_q;
    nxt_phase = '0;
    has_nxt   = 1'b0;
    for (int j = NPHASE - 1; j >= 1; j--) begin
      if (PW'(j) > phase_q && !eff_skip[j]) begin
        nxt_phase = PW'(j);
        has_nxt   = 1'b1;
      end
    end
  end

  assign instr_end = active && (DONE || (last_tick && !has_nxt));

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    tick_d      = tick_q;
    halt_pend_d = halt_pend_q;
    skip_lat_d  = skip_lat_q;
    case (state_q)
      S_IDLE: begin
        halt_pend_d = 1'b0;
        phase_d     = '0;
        tick_d      = '0;
        if (go_q[0]) begin
          state_d     = S_RUN;
          halt_pend_d = HALT;
        end else if (go_q[1]) begin
          state_d = S_STEP;
        end
      end
      default: begin
        halt_pend_d = halt_pend_q | HALT;
        if (phase_q == '0 && last_tick) skip_lat_d = eff_skip;
        if (instr_end) begin
          phase_d = '0;
          tick_d  = '0;
          if (state_q == S_STEP || halt_pend_d) begin
            state_d     = S_IDLE;
            halt_pend_d = 1'b0;
          end
        end else if (last_tick) begin
          tick_d  = '0;
          phase_d = nxt_phase;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      tick_q      <= '0;
      halt_pend_q <= 1'b0;
      skip_lat_q  <= '0;
      deb_cnt_q   <= '0;
      deb_stb_q   <= '0;
      go_q        <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tick_q      <= tick_d;
      halt_pend_q <= halt_pend_d;
      skip_lat_q  <= skip_lat_d;
      deb_cnt_q   <= deb_cnt_d;
      deb_stb_q   <= deb_stb_d;
      go_q        <= go_d;
    end
  end

  // Enables and strobes drop combinationally in the reset cycle itself.
  always_comb begin
    for (int i = 0; i < NPHASE; i++) begin
      CK[i]  = active && !RESET && (phase_q == PW'(i));
      STB[i] = active && !RESET && (phase_q == PW'(i)) && last_tick;
    end
  end

  assign INSTR_END = instr_end && !RESET;
  assign PHASE     = phase_q;
  assign running   = active;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed and randomized bench for phase_sequencer
// against an instruction-level reference model (phase list per instruction).
module tb_phase_sequencer;

  localparam int N   = 10;
  localparam int T   = 2;
  localparam int DEB = 4;

  logic         CLK = 1'b0;
  logic         RESET, RUN, STEP, HALT, DONE;
  logic [N-1:0] SKIP;
  logic [N-1:0] CK, STB;
  logic [3:0]   PHASE;
  logic         INSTR_END, running;

  always #5 CLK = ~CLK;

  phase_sequencer #(.NPHASE(N), .TICKS(T), .DEB_LIMIT(DEB)) dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP), .HALT(HALT), .DONE(DONE),
    .SKIP(SKIP), .CK(CK), .STB(STB), .PHASE(PHASE), .INSTR_END(INSTR_END),
    .running(running)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 idle, 1 run, 2 step; m_k = cycle index within the instruction.
  int  m_state, m_k;
  bit  m_halt, m_end;
  int  m_list[$];
  int  rl_run, rl_step;
  bit  prev_run, prev_step, f_run, f_step, g_run, g_step;

  logic [N-1:0] e_ck, e_stb;
  logic [3:0]   e_ph;
  logic         e_ie, e_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_k = 0; m_halt = 0; m_end = 0;
    rl_run = 0; rl_step = 0; prev_run = 0; prev_step = 0;
    f_run = 0; f_step = 0; g_run = 0; g_step = 0;
  endtask

  task automatic build(input logic [N-1:0] sk);
    m_list.delete();
    for (int j = 1; j < N; j++) if (!sk[j]) m_list.push_back(j);
  endtask

  function automatic int cur_phase();
    int idx;
    idx = m_k / T;
    if (idx == 0) return 0;
    if (idx - 1 < m_list.size()) return m_list[idx - 1];
    return -1;
  endfunction

  task automatic eval();
    int idx, t, ph;
    e_ck = '0; e_stb = '0; e_ie = 1'b0; e_ph = '0; m_end = 0;
    e_run = (m_state != 0);
    if (m_state != 0) begin
      if (m_k == T - 1) build(SKIP);
      idx = m_k / T;
      t   = m_k % T;
      ph  = cur_phase();
      if (ph < 0) ph = 0;
      e_ph  = 4'(ph);
      m_end = DONE || (t == T - 1 && idx == m_list.size());
      if (!RESET) begin
        e_ck[ph]  = 1'b1;
        e_stb[ph] = (t == T - 1);
        e_ie      = m_end;
      end
    end
  endtask

  task automatic deb_update(input bit raw, inout int rl, inout bit prev, inout bit f, output bit g);
    rl   = (raw == prev) ? rl + 1 : 1;
    prev = raw;
    g    = 0;
    if (rl == DEB && raw != f) begin
      f = raw;
      g = raw;
    end
  endtask

  task automatic advance();
    if (RESET) begin
      model_reset();
      return;
    end
    if (m_state == 0) begin
      if (g_run) begin m_state = 1; m_k = 0; m_halt = HALT; end
      else if (g_step) begin m_state = 2; m_k = 0; m_halt = 0; end
    end else begin
      if (HALT) m_halt = 1;
      if (m_end) begin
        m_k = 0;
        if (m_state == 2 || m_halt) begin m_state = 0; m_halt = 0; end
      end else begin
        m_k++;
      end
    end
    deb_update(RUN, rl_run, prev_run, f_run, g_run);
    deb_update(STEP, rl_step, prev_step, f_step, g_step);
  endtask

  task automatic cyc();
    #1;
    eval();
    chk("CK", 32'(CK), 32'(e_ck));
    chk("STB", 32'(STB), 32'(e_stb));
    chk("PHASE", 32'(PHASE), 32'(e_ph));
    chk("INSTR_END", 32'(INSTR_END), 32'(e_ie));
    chk("running", 32'(running), 32'(e_run));
    advance();
    @(negedge CLK);
  endtask

  task automatic wait_phase(input int ph, input int tk, input int budget, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (m_state != 0 && cur_phase() == ph && (m_k % T) == tk) found = 1;
      else cyc();
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    RESET = 1; RUN = 0; STEP = 0; HALT = 0; DONE = 0; SKIP = '0;
    @(posedge CLK);
    @(negedge CLK);
    model_reset();
    repeat (2) cyc();
    RESET = 0;
    repeat (8) cyc();

    // Full run with no skips, then back-to-back restart.
    RUN = 1; repeat (6) cyc(); RUN = 0;
    repeat (50) cyc();

    // Skip mask leaves phases 0, 8, 9.
    SKIP = 10'b0011111110;
    repeat (30) cyc();
    SKIP = '0;

    // DONE early in tick 0 of phase 3.
    wait_phase(3, 0, 40, "wait_ph3");
    DONE = 1; cyc(); DONE = 0;
    repeat (4) cyc();

    // One-cycle HALT during phase 2 stops at the boundary.
    wait_phase(2, 0, 40, "wait_ph2");
    HALT = 1; cyc(); HALT = 0;
    repeat (30) cyc();

    // Restart, then RESET mid phase 5.
    RUN = 1; repeat (6) cyc(); RUN = 0;
    wait_phase(5, 1, 40, "wait_ph5");
    RESET = 1; repeat (3) cyc(); RESET = 0;
    repeat (10) cyc();

    // STEP from idle with a RUN edge landing inside the step; DONE in idle afterwards.
    STEP = 1; repeat (2) cyc();
    RUN = 1; repeat (4) cyc();
    STEP = 0; repeat (2) cyc();
    RUN = 0; repeat (30) cyc();
    DONE = 1; repeat (3) cyc(); DONE = 0;
    repeat (4) cyc();

    // HALT coincident with the RUN start: exactly one instruction.
    HALT = 1; RUN = 1; repeat (6) cyc();
    HALT = 0; RUN = 0; repeat (30) cyc();

    // Randomized mix of all controls.
    for (int i = 0; i < 400; i++) begin
      SKIP  = N'($urandom);
      DONE  = ($urandom_range(0, 19) == 0);
      HALT  = ($urandom_range(0, 39) == 0);
      RESET = ($urandom_range(0, 149) == 0);
      if (i % 12 == 0) begin
        RUN  = 1'($urandom_range(0, 1));
        STEP = 1'($urandom_range(0, 1));
      end
      cyc();
    end
    RESET = 0; DONE = 0; HALT = 0;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
